// File: rtl/spi_mem_arbiter_pkg.sv
// spi_mem_arbiter_pkg: access types and arbiter states shared by the flash/PSRAM arbiter.
package spi_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        TYPE_IMEM_READ  = 2'd0,
        TYPE_DMEM_READ  = 2'd1,
        TYPE_DMEM_WRITE = 2'd2
    } mem_type_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_BUSY,
        ST_WAIT_DONE,
        ST_RESP
    } arb_state_t;

endpackage

// File: rtl/spi_mem_arbiter.sv
// spi_mem_arbiter: round-robin sharing of one SPI memory controller between two ports,
// one transaction in flight, with a saturating timeout guard.
module spi_mem_arbiter
    import spi_mem_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk_in,
    input  logic        reset_in,
    input  logic [1:0]  req_in,
    input  logic [31:0] addr_in,
    input  logic [3:0]  type_in,
    input  logic [15:0] wdata_in,
    output logic [1:0]  grant_out,
    output logic [1:0]  done_out,
    output logic        err_out,
    output logic [15:0] rdata_out,
    output logic [15:0] mem_addr_out,
    output logic        mem_valid_out,
    output mem_type_t   mem_type_out,
    output logic [7:0]  mem_wdata_out,
    input  logic [15:0] flash_data_in,
    input  logic        flash_valid_in,
    input  logic [7:0]  psram_data_in,
    input  logic        psram_valid_in,
    input  logic        mem_busy_in
);

    localparam int CW = $clog2(TIMEOUT + 1);

    arb_state_t    state_q, state_d;
    logic          rr_q, rr_d;
    logic [1:0]    grant_q, grant_d, done_q, done_d;
    logic          err_q, err_d, valid_q, valid_d;
    logic [15:0]   rdata_q, rdata_d, addr_q, addr_d;
    mem_type_t     type_q, type_d;
    logic [7:0]    wdata_q, wdata_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          win, timed_out, fin_early, fin_done;
    logic [15:0]   rsp_data;

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state_q <= ST_IDLE;
            rr_q    <= 1'b1;
            grant_q <= '0;
            done_q  <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            addr_q  <= '0;
            valid_q <= 1'b0;
            type_q  <= TYPE_IMEM_READ;
            wdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            addr_q  <= addr_d;
            valid_q <= valid_d;
            type_q  <= type_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        grant_d   = grant_q;
        done_d    = '0;
        err_d     = 1'b0;
        rdata_d   = rdata_q;
        addr_d    = addr_q;
        valid_d   = 1'b0;
        type_d    = type_q;
        wdata_d   = wdata_q;
        cnt_d     = cnt_q;
        // On a tie the port that did not win last time goes next
        win       = (&req_in) ? ~rr_q : req_in[1];
        timed_out = cnt_q == CW'(TIMEOUT);
        fin_early = flash_valid_in | psram_valid_in;
        fin_done  = (type_q == TYPE_IMEM_READ) ? flash_valid_in :
                    (type_q == TYPE_DMEM_READ) ? psram_valid_in : !mem_busy_in;
        rsp_data  = (type_q == TYPE_IMEM_READ) ? flash_data_in :
                    (type_q == TYPE_DMEM_READ) ? {8'h00, psram_data_in} : 16'h0000;
        case (state_q)
            ST_IDLE: if (|req_in) begin
                grant_d = win ? 2'b10 : 2'b01;
                rr_d    = win;
                addr_d  = win ? addr_in[31:16] : addr_in[15:0];
                type_d  = mem_type_t'(win ? type_in[3:2] : type_in[1:0]);
                wdata_d = win ? wdata_in[15:8] : wdata_in[7:0];
                state_d = ST_ISSUE;
            end
            ST_ISSUE: if (!mem_busy_in) begin
                valid_d = 1'b1;
                cnt_d   = '0;
                state_d = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY, ST_WAIT_DONE: begin
                cnt_d = timed_out ? cnt_q : cnt_q + 1'b1;
                if ((state_q == ST_WAIT_BUSY) ? fin_early : fin_done) begin
                    done_d  = grant_q;
                    rdata_d = rsp_data;
                    state_d = ST_RESP;
                end else if (timed_out) begin
                    done_d  = grant_q;
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = ST_RESP;
                end else if (state_q == ST_WAIT_BUSY && mem_busy_in) begin
                    state_d = ST_WAIT_DONE;
                end
            end
            ST_RESP: begin
                grant_d = '0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign grant_out     = grant_q;
    assign done_out      = done_q;
    assign err_out       = err_q;
    assign rdata_out     = rdata_q;
    assign mem_addr_out  = addr_q;
    assign mem_valid_out = valid_q;
    assign mem_type_out  = type_q;
    assign mem_wdata_out = wdata_q;

endmodule

// File: tb/tb_spi_mem_arbiter.sv
// tb_spi_mem_arbiter: scoreboard bench; stimulus queues expected issues/responses,
// a negedge monitor pops and compares whenever the arbiter issues or completes.
module tb_spi_mem_arbiter;
    import spi_mem_arbiter_pkg::*;

    localparam int TO = 40;
    localparam int M_FLASH = 0, M_PSRAM = 1, M_WRITE = 2;

    logic        clk_in = 1'b0, reset_in = 1'b1;
    logic [1:0]  req_in = '0;
    logic [31:0] addr_in = '0;
    logic [3:0]  type_in = '0;
    logic [15:0] wdata_in = '0;
    logic [1:0]  grant_out, done_out;
    logic        err_out, mem_valid_out;
    logic [15:0] rdata_out, mem_addr_out;
    mem_type_t   mem_type_out;
    logic [7:0]  mem_wdata_out;
    logic [15:0] flash_data_in = '0;
    logic        flash_valid_in = 1'b0;
    logic [7:0]  psram_data_in = '0;
    logic        psram_valid_in = 1'b0, mem_busy_in = 1'b0;

    int n_vec = 0, n_miss = 0;
    logic [27:0] iss_q[$];
    logic [18:0] rsp_q[$];

    spi_mem_arbiter #(.TIMEOUT(TO)) dut (
        .clk_in(clk_in), .reset_in(reset_in), .req_in(req_in), .addr_in(addr_in),
        .type_in(type_in), .wdata_in(wdata_in), .grant_out(grant_out), .done_out(done_out),
        .err_out(err_out), .rdata_out(rdata_out), .mem_addr_out(mem_addr_out),
        .mem_valid_out(mem_valid_out), .mem_type_out(mem_type_out), .mem_wdata_out(mem_wdata_out),
        .flash_data_in(flash_data_in), .flash_valid_in(flash_valid_in),
        .psram_data_in(psram_data_in), .psram_valid_in(psram_valid_in), .mem_busy_in(mem_busy_in)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk_in) begin
        if (mem_valid_out) begin
            if (iss_q.size() == 0) check("unexpected_issue", {grant_out, mem_addr_out}, 64'hFFFF_FFFF);
            else check("issue", {grant_out, mem_addr_out, mem_type_out, mem_wdata_out}, iss_q.pop_front());
        end
        if (done_out != 2'b00) begin
            if (rsp_q.size() == 0) check("unexpected_done", {done_out, err_out, rdata_out}, 64'hFFFF_FFFF);
            else check("response", {done_out, err_out, rdata_out}, rsp_q.pop_front());
        end
    end

    task automatic set_port(input int p, input mem_type_t t, input logic [15:0] a, input logic [7:0] w);
        type_in[p*2 +: 2]   = t;
        addr_in[p*16 +: 16] = a;
        wdata_in[p*8 +: 8]  = w;
    endtask

    task automatic expect_txn(input int p, input mem_type_t t, input logic [15:0] a, input logic [7:0] w,
                              input logic e, input logic [15:0] rd);
        logic [1:0] g;
        g = (p == 1) ? 2'b10 : 2'b01;
        iss_q.push_back({g, a, t, w});
        rsp_q.push_back({g, e, rd});
    endtask

    task automatic wait_valid();
        int n = 0;
        @(negedge clk_in);
        while (!mem_valid_out && n < 100) begin
            @(negedge clk_in);
            n++;
        end
        if (!mem_valid_out) begin
            n_vec++;
            n_miss++;
            $display("FAIL valid_wait: mem_valid_out low after 100 cycles, required high");
        end
    endtask

    task automatic serve(input int mode, input int busy_cyc, input logic [15:0] d);
        wait_valid();
        @(posedge clk_in); #1;
        mem_busy_in = (busy_cyc > 0);
        repeat (busy_cyc) @(posedge clk_in);
        #1;
        mem_busy_in = 1'b0;
        if (mode == M_FLASH) begin flash_valid_in = 1'b1; flash_data_in = d; end
        if (mode == M_PSRAM) begin psram_valid_in = 1'b1; psram_data_in = d[7:0]; end
        @(posedge clk_in); #1;
        flash_valid_in = 1'b0;
        psram_valid_in = 1'b0;
    endtask

    task automatic wait_done(input logic [1:0] drop);
        int n = 0;
        while (done_out == 2'b00 && n < 300) begin
            @(posedge clk_in); #1;
            n++;
        end
        if (done_out == 2'b00) begin
            n_vec++;
            n_miss++;
            $display("FAIL done_wait: done_out 00 after 300 cycles, required nonzero");
        end
        @(posedge clk_in); #1;
        req_in = req_in & ~drop;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1);
    end

    initial begin
        int n;
        set_port(0, TYPE_IMEM_READ, 16'h0100, 8'h00);
        set_port(1, TYPE_DMEM_READ, 16'h1234, 8'h00);
        req_in = 2'b11;
        repeat (3) @(negedge clk_in);
        check("reset_outputs", {grant_out, done_out, err_out, rdata_out, mem_addr_out,
                                mem_valid_out, mem_type_out, mem_wdata_out}, 64'h0);
        @(posedge clk_in); #1;
        reset_in = 1'b0;

        // Both ports requesting from reset: strict alternation starting with port 0
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 0) begin
                expect_txn(0, TYPE_IMEM_READ, 16'h0100, 8'h00, 1'b0, 16'h1111 + 16'(k));
                serve(M_FLASH, 0, 16'h1111 + 16'(k));
            end else begin
                expect_txn(1, TYPE_DMEM_READ, 16'h1234, 8'h00, 1'b0, {8'h00, 8'hA0 + 8'(k)});
                serve(M_PSRAM, 2, {8'h00, 8'hA0 + 8'(k)});
            end
            wait_done((k == 3) ? 2'b11 : 2'b00);
        end

        set_port(0, TYPE_IMEM_READ, 16'h0012, 8'h00);
        expect_txn(0, TYPE_IMEM_READ, 16'h0012, 8'h00, 1'b0, 16'hBEEF);
        req_in = 2'b01;
        serve(M_FLASH, 19, 16'hBEEF);
        wait_done(2'b01);

        set_port(1, TYPE_DMEM_WRITE, 16'h2000, 8'h5A);
        expect_txn(1, TYPE_DMEM_WRITE, 16'h2000, 8'h5A, 1'b0, 16'h0000);
        req_in = 2'b10;
        serve(M_WRITE, 30, 16'h0000);
        @(negedge clk_in);
        check("write_done_after_busy_fall", done_out, 2'b10);
        wait_done(2'b10);

        mem_busy_in = 1'b1;
        set_port(0, TYPE_DMEM_READ, 16'h0456, 8'h00);
        expect_txn(0, TYPE_DMEM_READ, 16'h0456, 8'h00, 1'b0, 16'h0077);
        req_in = 2'b01;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk_in);
            check("issue_held_while_busy", mem_valid_out, 1'b0);
        end
        @(posedge clk_in); #1;
        mem_busy_in = 1'b0;
        serve(M_PSRAM, 2, 16'h0077);
        wait_done(2'b01);

        // Silent controller: error response exactly TO+1 cycles after the valid cycle
        flash_data_in = 16'hDEAD;
        set_port(1, TYPE_IMEM_READ, 16'h3000, 8'h00);
        expect_txn(1, TYPE_IMEM_READ, 16'h3000, 8'h00, 1'b1, 16'h0000);
        req_in = 2'b10;
        wait_valid();
        n = 0;
        do begin
            @(negedge clk_in);
            n++;
        end while (done_out == 2'b00 && n < 100);
        check("timeout_latency", n, TO + 1);
        wait_done(2'b10);

        set_port(1, TYPE_DMEM_READ, 16'h3002, 8'h00);
        expect_txn(1, TYPE_DMEM_READ, 16'h3002, 8'h00, 1'b0, 16'h00C3);
        req_in = 2'b10;
        serve(M_PSRAM, 0, 16'h00C3);
        wait_done(2'b10);

        set_port(0, TYPE_IMEM_READ, 16'h0ABC, 8'h00);
        iss_q.push_back({2'b01, 16'h0ABC, TYPE_IMEM_READ, 8'h00});
        req_in = 2'b01;
        wait_valid();
        @(posedge clk_in); #1;
        mem_busy_in = 1'b1;
        repeat (3) @(posedge clk_in);
        #2;
        check("grant_before_reset", grant_out, 2'b01);
        reset_in = 1'b1;
        req_in = 2'b11;
        #1;
        check("async_reset_outputs", {grant_out, done_out, err_out, rdata_out, mem_addr_out,
                                      mem_valid_out, mem_type_out, mem_wdata_out}, 64'h0);
        rsp_q.delete();
        @(posedge clk_in); #1;
        mem_busy_in = 1'b0;
        @(posedge clk_in); #1;
        reset_in = 1'b0;
        expect_txn(0, TYPE_IMEM_READ, 16'h0ABC, 8'h00, 1'b0, 16'hCAFE);
        serve(M_FLASH, 1, 16'hCAFE);
        wait_done(2'b11);

        repeat (5) @(negedge clk_in);
        check("issue_queue_drained", iss_q.size(), 0);
        check("response_queue_drained", rsp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
